// File: rtl/cmm_pkg.sv
// Shared definitions for the complex matrix datapath (packer, adder, unpacker).
//   FILL / HOLD : packer state encoding
//   cnt_w       : width of an element-slot counter for an n-element matrix
//   slot_lsb    : bit offset of element slot k in a packed matrix word
package cmm_pkg;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slot_lsb(input int k, input int esize);
    return k * esize;
  endfunction

endpackage

// File: rtl/complex_matrix_packer.sv
// Element-serial to matrix-parallel AXI-Stream packer.
// Collects MAT_HEIGHT*MAT_WIDTH complex elements (row-major) and emits them
// as one full-width matrix beat.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready  element input stream
//   s_axis_tlast                closes the current matrix
//   s_axis_tuser                on the closing beat: matrix is last of its batch
//   m_axis_tdata/tvalid/tready  packed matrix output stream
//   m_axis_tlast                last matrix of batch
//   m_axis_tuser                framing error (tlast early or missing)
module complex_matrix_packer
  import cmm_pkg::*;
#(
  parameter int MAT_WIDTH    = 4,
  parameter int MAT_HEIGHT   = 4,
  parameter int ELEMENT_SIZE = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [ELEMENT_SIZE-1:0]                   s_axis_tdata,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic                                      s_axis_tlast,
  input  logic                                      s_axis_tuser,
  output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] m_axis_tdata,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic                                      m_axis_tuser
);

  localparam int N     = MAT_WIDTH * MAT_HEIGHT;
  localparam int CNT_W = cnt_w(N);

  logic [0:0]       state;
  logic [0:0]       state_nx;
  logic [CNT_W-1:0] count;
  logic             ready_r;
  logic             tlast_r;
  logic             err_r;
  logic             s_hs;
  logic             m_hs;
  logic             last_slot;
  logic             closing;

  assign s_hs      = s_axis_tvalid & ready_r;
  assign m_hs      = (state == HOLD) & m_axis_tready;
  assign last_slot = (count == CNT_W'(N - 1));
  assign closing   = s_hs & (s_axis_tlast | last_slot);

  always_comb begin
    state_nx = state;
    if (state == FILL) begin
      if (closing) state_nx = HOLD;
    end else begin
      if (m_hs) state_nx = FILL;
    end
  end

  // ready is registered from the next state, so it carries no combinational
  // path from m_axis_tready and is low for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FILL;
      count   <= '0;
      ready_r <= 1'b0;
      tlast_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_r <= (state_nx == FILL);
      if (state == FILL) begin
        if (closing) begin
          tlast_r <= s_axis_tuser;
          err_r   <= (s_axis_tlast != last_slot);
        end else if (s_hs) begin
          count <= count + CNT_W'(1);
        end
      end else if (m_hs) begin
        count   <= '0;
        tlast_r <= 1'b0;
        err_r   <= 1'b0;
      end
    end
  end

  // One register per element slot; a slot is written only when the counter
  // points at it, and all slots clear together once the matrix is taken.
  for (genvar k = 0; k < N; k++) begin : g_slot
    logic                    wr_en;
    logic [ELEMENT_SIZE-1:0] q;

    assign wr_en = s_hs & (count == CNT_W'(k));

    always_ff @(posedge clk) begin
      if (reset || m_hs) q <= '0;
      else if (wr_en)    q <= s_axis_tdata;
    end

    assign m_axis_tdata[slot_lsb(k, ELEMENT_SIZE) +: ELEMENT_SIZE] = q;
  end

  assign s_axis_tready = ready_r;
  assign m_axis_tvalid = (state == HOLD);
  assign m_axis_tlast  = tlast_r;
  assign m_axis_tuser  = err_r;

endmodule

// File: tb/tb_complex_matrix_packer.sv
module tb_complex_matrix_packer;

  localparam int N  = 16;
  localparam int ES = 16;
  localparam int MW = N * ES;

  typedef struct {
    logic [MW-1:0] data;
    logic          last;
    logic          user;
  } mat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [ES-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic [MW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          m_tuser;

  complex_matrix_packer #(.MAT_WIDTH(4), .MAT_HEIGHT(4), .ELEMENT_SIZE(ES)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int prev_hs = 0;
  bit rand_mr = 1'b0;

  mat_t          sb_q[$];
  int            mcount = 0;
  logic [MW-1:0] mbuf = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted element.
  task automatic model_beat(input logic [ES-1:0] d, input bit l, input bit u);
    mat_t m;
    bit   at_end;
    at_end = (mcount == N - 1);
    mbuf[mcount*ES +: ES] = d;
    if (l || at_end) begin
      m.data = mbuf;
      m.last = u;
      m.user = (l != at_end);
      sb_q.push_back(m);
      mbuf   = '0;
      mcount = 0;
    end else begin
      mcount++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input logic [ES-1:0] d, input bit l, input bit u);
    int n;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 500) begin
        chk("s_ready_timeout", 1, 0);
        break;
      end
    end
    model_beat(d, l, u);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_matrix(input int base, input bit u, input bit gaps);
    for (int i = 0; i < N; i++) begin
      send_beat(ES'(base + i), (i == N - 1), u);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sb_q.size(), 0);
  endtask

  // Output monitor: a matrix seen valid&ready here is taken at the next edge.
  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) begin
      prev_hs = last_hs;
      last_hs = cyc;
      if (sb_q.size() == 0) begin
        chk("unexpected_matrix", 1, 0);
      end else begin
        mat_t e;
        e = sb_q.pop_front();
        chk("m_tdata", m_tdata, e.data);
        chk("m_tlast", MW'(m_tlast), MW'(e.last));
        chk("m_tuser", MW'(m_tuser), MW'(e.user));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mr) m_tready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [MW-1:0] held;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", MW'(s_tready), 0);
    chk("rst_m_valid", MW'(m_tvalid), 0);
    chk("rst_m_tlast", MW'(m_tlast), 0);
    chk("rst_m_tuser", MW'(m_tuser), 0);
    chk("rst_m_tdata", m_tdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1) Clean matrix 0x0101*(k+1), tuser=1; valid right after the closing beat
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) send_beat(ES'(16'h0101 * (i + 1)), (i == N - 1), 1'b1);
    chk("t1_latency_valid", MW'(m_tvalid), 1);
    chk("t1_slot0", MW'(m_tdata[15:0]), MW'(16'h0101));
    chk("t1_slot15", MW'(m_tdata[MW-1 -: 16]), MW'(16'h1010));
    chk("t1_tlast", MW'(m_tlast), 1);
    chk("t1_tuser", MW'(m_tuser), 0);
    m_tready = 1'b1;
    // Two back-to-back unstalled matrices: N+1 cycles apart
    send_matrix(16'h2000, 1'b0, 1'b0);
    send_matrix(16'h3000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_throughput", MW'(last_hs - prev_hs), MW'(N + 1));
    drain();

    // 2) Early tlast after 3 elements, then a clean matrix
    send_beat(16'hAAAA, 1'b0, 1'b0);
    send_beat(16'hBBBB, 1'b0, 1'b0);
    m_tready = 1'b0;
    send_beat(16'hCCCC, 1'b1, 1'b0);
    chk("t2_early_data", m_tdata, MW'(48'hCCCC_BBBB_AAAA));
    chk("t2_early_tuser", MW'(m_tuser), 1);
    m_tready = 1'b1;
    send_matrix(16'h4000, 1'b1, 1'b0);
    drain();

    // 3) 16 beats without tlast, then the 17th starts a new matrix at slot 0
    for (int i = 0; i < N; i++) send_beat(ES'(16'h5000 + i), 1'b0, 1'b0);
    send_matrix(16'h6000, 1'b0, 1'b0);
    drain();

    // 4) Backpressure for 10 cycles while holding
    m_tready = 1'b0;
    send_matrix(16'h7000, 1'b1, 1'b0);
    held = m_tdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", MW'(m_tvalid), 1);
      chk("t4_hold_data", m_tdata, held);
      chk("t4_hold_s_ready", MW'(s_tready), 0);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_after_valid", MW'(m_tvalid), 0);
    chk("t4_after_s_ready", MW'(s_tready), 1);
    drain();

    // 5) Random gaps and backpressure, 50 matrices incl. some framing errors
    rand_mr = 1'b1;
    for (int m = 0; m < 50; m++) begin
      if (m % 7 == 3) begin
        int len;
        len = $urandom_range(1, N - 1);
        for (int i = 0; i < len; i++) send_beat(ES'($urandom), (i == len - 1), m[0]);
      end else begin
        send_matrix(int'($urandom_range(0, 16'hFFFF)), m[0], 1'b1);
      end
    end
    drain();
    rand_mr = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;

    // 6) Reset after 7 beats discards the partial matrix
    for (int i = 0; i < 7; i++) send_beat(ES'(16'hE000 + i), 1'b0, 1'b0);
    reset  = 1'b1;
    mcount = 0;
    mbuf   = '0;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", MW'(m_tvalid), 0);
    reset = 1'b0;
    send_matrix(16'h9100, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
